// File: rtl/io_peripheral_hub.sv
// io_peripheral_hub
//   Memory-mapped I/O slave for the Risc16 I/O bus: LED register, debounced
//   switches, prescaled 16-bit timer with overflow flag, and a 4-entry FIFO
//   feeding an 8N1 UART transmitter.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   io_address     bus address (full 16-bit decode)
//   io_write_value bus write data
//   io_read_value  bus read data, combinational from address and state
//   io_write_en    write strobe, sampled at rising clk
//   io_read_en     read qualifier, no side effects
//   sw             raw asynchronous switches
//   led            LED drive
//   uart_tx        serial TX line, idle high
//   timer_irq      timer overflow flag
//
// Address map
//   0x0000 LED     R/W
//   0x0001 SW      R   debounced switches
//   0x0002 TXDATA  W   push byte, reads 0
//   0x0003 STATUS  R   {overrun, count[2:0], tx_busy, empty, full}; W bit6=1 clears overrun
//   0x0004 TCOUNT  R/W write loads count and clears prescaler
//   0x0005 TCTRL   R   {ovf, enable}; W bit0 -> enable, bit1=1 clears ovf
//
// UART TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for FIFO data
//   TX_START | start bit (low)
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit (high); pops next byte straight into TX_START if available
module io_peripheral_hub #(
  parameter int CLK_HZ          = 100000000,
  parameter int BAUD            = 115200,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMER_PRESCALE  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_value,
  output logic [15:0] io_read_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (TIMER_PRESCALE > 2) ? $clog2(TIMER_PRESCALE) : 1;

  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [DW-1:0] DB_LOAD   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TIMER_PRESCALE - 1);

  localparam logic [15:0] ADDR_LED    = 16'h0000;
  localparam logic [15:0] ADDR_SW     = 16'h0001;
  localparam logic [15:0] ADDR_TXDATA = 16'h0002;
  localparam logic [15:0] ADDR_STATUS = 16'h0003;
  localparam logic [15:0] ADDR_TCOUNT = 16'h0004;
  localparam logic [15:0] ADDR_TCTRL  = 16'h0005;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic unused_read_en;
  assign unused_read_en = io_read_en;

  logic wr_led, wr_txdata, wr_status, wr_tcount, wr_tctrl;
  assign wr_led    = io_write_en && (io_address == ADDR_LED);
  assign wr_txdata = io_write_en && (io_address == ADDR_TXDATA);
  assign wr_status = io_write_en && (io_address == ADDR_STATUS);
  assign wr_tcount = io_write_en && (io_address == ADDR_TCOUNT);
  assign wr_tctrl  = io_write_en && (io_address == ADDR_TCTRL);

  // LED register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else if (wr_led) led <= io_write_value;
  end

  // Switch synchroniser and shared debounce down-counter. The counter
  // reloads on any change of the synchronised vector; reaching zero with the
  // vector still unchanged means it has been stable long enough.
  logic [15:0]   sw_sync1, sw_sync2, sw_prev, sw_stable;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1  <= '0;
      sw_sync2  <= '0;
      sw_prev   <= '0;
      sw_stable <= '0;
      db_cnt    <= DB_LOAD;
    end else begin
      sw_sync1 <= sw;
      sw_sync2 <= sw_sync1;
      sw_prev  <= sw_sync2;
      if (sw_sync2 != sw_prev) db_cnt <= DB_LOAD;
      else if (db_cnt == '0) sw_stable <= sw_sync2;
      else db_cnt <= db_cnt - 1'b1;
    end
  end

  // Timer
  logic [15:0]   tcount;
  logic [PW-1:0] prescale;
  logic          t_en, ovf, tick;

  assign tick = t_en && (prescale == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount   <= '0;
      prescale <= '0;
      t_en     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (wr_tcount) begin
        tcount   <= io_write_value;
        prescale <= '0;
      end else if (t_en) begin
        if (tick) begin
          prescale <= '0;
          tcount   <= tcount + 16'd1;
        end else begin
          prescale <= prescale + 1'b1;
        end
      end
      if (wr_tctrl) t_en <= io_write_value[0];
      // a wrap in the same cycle as a clear keeps the flag set
      if (tick && !wr_tcount && (tcount == 16'hFFFF)) ovf <= 1'b1;
      else if (wr_tctrl && io_write_value[1]) ovf <= 1'b0;
    end
  end

  assign timer_irq = ovf;

  // TX FIFO
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, fifo_empty, fifo_pop, push_ok, overrun;

  logic [1:0]    tx_state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_shift;
  logic          tx_busy;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_pop   = !fifo_empty &&
                      ((tx_state == TX_IDLE) ||
                       ((tx_state == TX_STOP) && (baud_cnt == '0)));
  // a simultaneous pop frees a slot, so a full FIFO can still accept
  assign push_ok    = wr_txdata && (!fifo_full || fifo_pop);
  assign tx_busy    = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= io_write_value[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push_ok} - {2'b00, fifo_pop};
      if (wr_txdata && !push_ok) overrun <= 1'b1;
      else if (wr_status && io_write_value[6]) overrun <= 1'b0;
    end
  end

  // UART transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            baud_cnt <= BAUD_LOAD;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            bit_cnt  <= '0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          if (baud_cnt == '0) begin
            if (fifo_pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              baud_cnt <= BAUD_LOAD;
              uart_tx  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Read mux
  always_comb begin
    io_read_value = '0;
    case (io_address)
      ADDR_LED:    io_read_value = led;
      ADDR_SW:     io_read_value = sw_stable;
      ADDR_STATUS: io_read_value = {9'd0, overrun, fifo_cnt, tx_busy, fifo_empty, fifo_full};
      ADDR_TCOUNT: io_read_value = tcount;
      ADDR_TCTRL:  io_read_value = {14'd0, ovf, t_en};
      default:     io_read_value = '0;
    endcase
  end

endmodule

// File: tb/tb_io_peripheral_hub.sv
// Testbench for io_peripheral_hub with small parameters: baud divider 10,
// debounce 8 cycles, timer prescale 2.
module tb_io_peripheral_hub;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DB     = 8;
  localparam int PRE    = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] io_address;
  logic [15:0] io_write_value;
  logic [15:0] io_read_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [15:0] sw;
  logic [15:0] led;
  logic        uart_tx;
  logic        timer_irq;

  int tests = 0;
  int fails = 0;
  logic [7:0] rxq[$];

  io_peripheral_hub #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEBOUNCE_CYCLES(DB), .TIMER_PRESCALE(PRE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_address(io_address),
    .io_write_value(io_write_value), .io_read_value(io_read_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .sw(sw), .led(led),
    .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // serial receiver: samples mid-bit and queues each framed byte
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        logic [7:0] b;
        repeat (DIV / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (DIV) @(negedge clk);
          if (uart_tx === 1'b1) rxq.push_back(b);
        end
      end
    end
  end

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_address = a;
    io_write_value = d;
    io_write_en = 1'b1;
    @(posedge clk);
    #1;
    io_write_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    io_address = a;
    #1;
    d = io_read_value;
  endtask

  task automatic test_reset();
    logic [15:0] r;
    logic [15:0] exp_v [6];
    exp_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000};
    rst_n = 1'b0;
    io_address = '0; io_write_value = '0; io_write_en = 1'b0; io_read_en = 1'b0; sw = '0;
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      @(negedge clk);
      bus_rd(16'(a), r);
      tests++;
      if (r !== exp_v[a]) begin
        fails++;
        $display("FAIL reset_read addr=%0d: got %h expected %h", a, r, exp_v[a]);
      end
    end
    tests++;
    if (uart_tx !== 1'b1 || led !== 16'h0 || timer_irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_pins: tx=%b led=%h irq=%b expected 1 0000 0", uart_tx, led, timer_irq);
    end
  endtask

  task automatic test_led();
    logic [15:0] r, v, a, exp_led;
    bus_wr(16'h0000, 16'hA5C3);
    bus_rd(16'h0000, r);
    tests++;
    if (led !== 16'hA5C3 || r !== 16'hA5C3) begin
      fails++;
      $display("FAIL led_write: led=%h read=%h expected a5c3", led, r);
    end
    bus_wr(16'h0010, 16'h1234);
    bus_rd(16'h0010, r);
    tests++;
    if (led !== 16'hA5C3 || r !== 16'h0000) begin
      fails++;
      $display("FAIL led_unmapped: led=%h read=%h expected a5c3 0000", led, r);
    end
    exp_led = 16'hA5C3;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      bus_wr(16'h0000, v);
      exp_led = v;
      a = 16'($urandom_range(16'h0006, 16'hFFFF));
      bus_wr(a, 16'($urandom));
      bus_rd(a, r);
      tests++;
      if (r !== 16'h0000) begin
        fails++;
        $display("FAIL unmapped_read addr=%h: got %h expected 0000", a, r);
      end
      bus_rd(16'h0000, r);
      tests++;
      if (led !== exp_led || r !== exp_led) begin
        fails++;
        $display("FAIL led_random: led=%h read=%h expected %h", led, r, exp_led);
      end
      bus_rd(16'h0002, r);
      tests++;
      if (r !== 16'h0000) begin
        fails++;
        $display("FAIL txdata_read: got %h expected 0000", r);
      end
    end
  endtask

  // Reference: the debounced value becomes the synchronised vector once
  // DB+1 consecutive synchronised samples agree. The synchronised sample
  // seen at edge k is the raw switch value captured two edges earlier.
  task automatic test_debounce();
    logic [15:0] hist[$];
    logic [15:0] m_stable, r;
    logic [15:0] pat_v[$];
    int          pat_n[$];
    int          k;
    bit          eq;
    m_stable = 16'h0;
    for (int i = 0; i < DB + 3; i++) hist.push_back(16'h0);
    pat_v.push_back(16'h00FF); pat_n.push_back(5);
    pat_v.push_back(16'h00FE); pat_n.push_back(3);
    pat_v.push_back(16'h00FF); pat_n.push_back(20);
    for (int i = 0; i < 8; i++) begin
      pat_v.push_back(16'($urandom));
      pat_n.push_back($urandom_range(1, 14));
    end
    pat_v.push_back(16'($urandom)); pat_n.push_back(15);
    foreach (pat_v[p]) begin
      for (int c = 0; c < pat_n[p]; c++) begin
        @(negedge clk);
        sw = pat_v[p];
        @(posedge clk);
        hist.push_back(sw);
        #1;
        k = hist.size() - 1;
        eq = 1'b1;
        for (int j = k - 2 - DB; j <= k - 2; j++)
          if (hist[j] !== hist[k-2]) eq = 1'b0;
        if (eq) m_stable = hist[k-2];
        bus_rd(16'h0001, r);
        tests++;
        if (r !== m_stable) begin
          fails++;
          $display("FAIL debounce_cycle p=%0d c=%0d: got %h expected %h", p, c, r, m_stable);
        end
        if (p < 3) begin
          tests++;
          if (r === 16'h00FE) begin
            fails++;
            $display("FAIL debounce_glitch: got %h expected not 00fe", r);
          end
        end
      end
      if (p == 2) begin
        tests++;
        if (r !== 16'h00FF) begin
          fails++;
          $display("FAIL debounce_settle: got %h expected 00ff", r);
        end
      end
    end
    tests++;
    if (r !== pat_v[pat_v.size()-1]) begin
      fails++;
      $display("FAIL debounce_final: got %h expected %h", r, pat_v[pat_v.size()-1]);
    end
  endtask

  task automatic test_uart_frame();
    logic [7:0]  fb [2];
    logic [15:0] r;
    logic        exp_tx;
    int          f, b;
    int          bad;
    fb[0] = 8'h55;
    fb[1] = 8'h0F;
    bus_wr(16'h0002, {8'h00, fb[0]});
    tests++;
    if (uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL tx_latency_push_edge: got %b expected 1", uart_tx);
    end
    bus_wr(16'h0002, {8'h00, fb[1]});
    bad = 0;
    for (int c = 0; c < 20 * DIV; c++) begin
      f = c / (10 * DIV);
      b = (c % (10 * DIV)) / DIV;
      if (b == 0) exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else exp_tx = fb[f][b-1];
      tests++;
      if (uart_tx !== exp_tx) begin
        fails++;
        if (bad < 5) $display("FAIL tx_wave c=%0d: got %b expected %b", c, uart_tx, exp_tx);
        bad++;
      end
      @(posedge clk);
      #1;
    end
    bus_rd(16'h0003, r);
    tests++;
    if (r !== 16'h0002 || uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL tx_done_status: status=%h tx=%b expected 0002 1", r, uart_tx);
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [7:0]  d [6];
    logic [15:0] r;
    bit          done;
    rxq.delete();
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) bus_wr(16'h0002, {8'h00, d[i]});
    bus_rd(16'h0003, r);
    tests++;
    if (r !== 16'h0065) begin
      fails++;
      $display("FAIL fifo_full_overrun: status=%h expected 0065", r);
    end
    bus_wr(16'h0003, 16'h0040);
    bus_rd(16'h0003, r);
    tests++;
    if (r !== 16'h0025) begin
      fails++;
      $display("FAIL overrun_clear: status=%h expected 0025", r);
    end
    done = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      @(posedge clk);
      #1;
      bus_rd(16'h0003, r);
      if (r === 16'h0002) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: status=%h expected 0002", r);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rxq.size() != 5) begin
      fails++;
      $display("FAIL frame_count: got %0d expected 5", rxq.size());
    end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      tests++;
      if (rxq[i] !== d[i]) begin
        fails++;
        $display("FAIL frame_byte %0d: got %h expected %h", i, rxq[i], d[i]);
      end
    end
  endtask

  // Reference: after enabling, m elapsed edges add floor(m/PRE) to the load
  // value; ovf is set once that sum passes 0xFFFF.
  task automatic test_timer();
    logic [15:0] r, rc, v, w;
    int          sum;
    logic [15:0] exp_ctrl;
    v = 16'hFFFE;
    bus_wr(16'h0004, v);
    bus_wr(16'h0005, 16'h0001);
    for (int m = 1; m <= 8; m++) begin
      @(posedge clk);
      #1;
      sum = int'(v) + m / PRE;
      exp_ctrl = (sum > 16'hFFFF) ? 16'h0003 : 16'h0001;
      bus_rd(16'h0004, r);
      bus_rd(16'h0005, rc);
      tests++;
      if (r !== 16'(sum) || rc !== exp_ctrl || timer_irq !== exp_ctrl[1]) begin
        fails++;
        $display("FAIL timer_wrap m=%0d: count=%h ctrl=%h irq=%b expected %h %h", m, r, rc, timer_irq, 16'(sum), exp_ctrl);
      end
    end
    bus_wr(16'h0005, 16'h0002);
    for (int m = 0; m < 5; m++) begin
      bus_rd(16'h0004, r);
      bus_rd(16'h0005, rc);
      tests++;
      if (r !== 16'h0002 || rc !== 16'h0000 || timer_irq !== 1'b0) begin
        fails++;
        $display("FAIL timer_disabled: count=%h ctrl=%h expected 0002 0000", r, rc);
      end
      @(posedge clk);
      #1;
    end
    v = 16'hFFF8 + 16'($urandom_range(0, 7));
    bus_wr(16'h0004, v);
    bus_wr(16'h0005, 16'h0001);
    for (int m = 1; m <= 20; m++) begin
      @(posedge clk);
      #1;
      sum = int'(v) + m / PRE;
      exp_ctrl = (sum > 16'hFFFF) ? 16'h0003 : 16'h0001;
      bus_rd(16'h0004, r);
      bus_rd(16'h0005, rc);
      tests++;
      if (r !== 16'(sum) || rc !== exp_ctrl) begin
        fails++;
        $display("FAIL timer_random v=%h m=%0d: count=%h ctrl=%h expected %h %h", v, m, r, rc, 16'(sum), exp_ctrl);
      end
    end
    bus_wr(16'h0005, 16'h0003);
    bus_rd(16'h0005, rc);
    tests++;
    if (rc !== 16'h0001) begin
      fails++;
      $display("FAIL ovf_clear: ctrl=%h expected 0001", rc);
    end
    bus_wr(16'h0004, 16'hFFFF);
    @(posedge clk);
    bus_wr(16'h0005, 16'h0003);
    bus_rd(16'h0005, rc);
    bus_rd(16'h0004, r);
    tests++;
    if (rc !== 16'h0003 || r !== 16'h0000 || timer_irq !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: ctrl=%h count=%h irq=%b expected 0003 0000 1", rc, r, timer_irq);
    end
    w = 16'($urandom_range(0, 16'hFFFE));
    @(posedge clk);
    bus_wr(16'h0004, w);
    bus_rd(16'h0004, r);
    tests++;
    if (r !== w) begin
      fails++;
      $display("FAIL tcount_write_wins: got %h expected %h", r, w);
    end
    @(posedge clk);
    #1;
    bus_rd(16'h0004, r);
    tests++;
    if (r !== w) begin
      fails++;
      $display("FAIL tcount_prescale_clear: got %h expected %h", r, w);
    end
    @(posedge clk);
    #1;
    bus_rd(16'h0004, r);
    tests++;
    if (r !== w + 16'd1) begin
      fails++;
      $display("FAIL tcount_next_tick: got %h expected %h", r, w + 16'd1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] r;
    logic [15:0] exp_v [6];
    exp_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000};
    bus_wr(16'h0000, 16'($urandom) | 16'h0001);
    bus_wr(16'h0002, 16'($urandom_range(0, 255)));
    repeat (25) @(posedge clk);
    #1;
    bus_rd(16'h0003, r);
    tests++;
    if (r[2] !== 1'b1 || timer_irq !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_busy: status=%h irq=%b expected busy=1 irq=1", r, timer_irq);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (uart_tx !== 1'b1 || led !== 16'h0 || timer_irq !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_pins: tx=%b led=%h irq=%b expected 1 0000 0", uart_tx, led, timer_irq);
    end
    for (int a = 0; a < 6; a++) begin
      bus_rd(16'(a), r);
      tests++;
      if (r !== exp_v[a]) begin
        fails++;
        $display("FAIL async_reset_read addr=%0d: got %h expected %h", a, r, exp_v[a]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_rd(16'h0003, r);
    tests++;
    if (r !== 16'h0002 || uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_idle: status=%h tx=%b expected 0002 1", r, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_debounce();
    test_uart_frame();
    test_back_to_back_overrun();
    test_timer();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_peripheral_hub.md
Name: io_peripheral_hub

Overview:
Memory-mapped I/O slave that sits directly downstream of the Risc16 core's I/O bus (io_address, io_write_value, io_read_value, io_write_en, io_read_en) and replaces ad-hoc LED/switch glue at board top level. It provides:
- an LED output register;
- synchronised, debounced switch inputs;
- a prescaled 16-bit timer with overflow flag;
- a 4-entry FIFO feeding an 8N1 UART transmitter.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_HZ/BAUD (integer division, must be >= 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a switch change is accepted
TIMER_PRESCALE, 100, clock cycles per timer tick (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
io_address  input  16  bus address from core
io_write_value  input  16  write data from core
io_read_value  output  16  read data to core, combinational
io_write_en  input  1  write strobe, sampled at rising clk
io_read_en  input  1  read qualifier; no side effects, not required for read data
sw  input  16  raw asynchronous switches
led  output  16  LED drive
uart_tx  output  1  serial TX line, idle high
timer_irq  output  1  equals timer overflow flag

Behaviour:
- Reset (rst_n low, asynchronous): led=0, stable switches=0, synchroniser flops=0, timer count=0, prescaler=0, enable=0, ovf=0, FIFO empty, overrun=0, TX idle, uart_tx=1, timer_irq=0. Reset mid-frame aborts the frame; uart_tx goes high immediately.
- Address map (full 16-bit decode):
  - 0x0000 LED: R/W.
  - 0x0001 SW: R, debounced value.
  - 0x0002 TXDATA: W pushes io_write_value[7:0]; R=0.
  - 0x0003 STATUS: R bit0 full, bit1 empty, bit2 tx_busy, bits[5:3] FIFO count (0-4), bit6 overrun, others 0. W with bit6=1 clears overrun.
  - 0x0004 TCOUNT: R count; W loads count and clears prescaler.
  - 0x0005 TCTRL: R bit0 enable, bit1 ovf. W bit0 sets enable; bit1=1 clears ovf.
  - Unmapped addresses: read 0; writes ignored.
- Write timing: a write takes effect at the rising edge where io_write_en=1. Read data reflects it from the next cycle. Reads are purely combinational from io_address and registered state.
- Switches:
  - 2-flop synchroniser per bit, then one shared counter.
  - The counter clears whenever the synchronised vector differs from the previous cycle's.
  - When the vector has been unchanged for DEBOUNCE_CYCLES consecutive cycles, it is copied to the stable register.
- Timer:
  - While enabled, the prescaler counts 0..TIMER_PRESCALE-1.
  - On prescaler wrap, count increments. 0xFFFF->0x0000 sets ovf.
  - An ovf set and a W1C clear in the same cycle: set wins.
  - A TCOUNT write in the same cycle as a tick: write wins.
- FIFO: 4 entries, 3-bit count.
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun is set (sticky).
- UART TX state machine:
  - States: IDLE, START, DATA(8 bits, LSB first), STOP.
  - Each bit lasts BAUD_DIV cycles.
  - In IDLE with FIFO non-empty: pop at that edge; uart_tx=0 from that edge.
  - At the end of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - tx_busy=1 in every state except IDLE.
  - Latency: push at edge N -> pop and start bit at edge N+1. Frame length is 10*BAUD_DIV cycles.

Test Plan:
1. Reset, then read all addresses -> LED=0, SW=0, STATUS=0x0002, TCOUNT=0, TCTRL=0; uart_tx=1, led=0.
2. Write 0xA5C3 to 0x0000 -> led=0xA5C3 next cycle, read back 0xA5C3. Write to 0x0010 -> led unchanged, read of 0x0010 = 0.
3. DEBOUNCE_CYCLES=8. sw=0x00FF with a 3-cycle glitch to 0x00FE, then steady -> SW reads 0x00FF only after 8 stable synchronised cycles; the glitch is never visible.
4. CLK_HZ=1000, BAUD=100 (div 10). Push 0x55, 0x0F back-to-back:
   - uart_tx low one cycle after the first push;
   - bits 1,0,1,0,1,0,1,0 each 10 cycles, then stop;
   - second frame starts immediately, total 200 cycles;
   - then tx_busy=0 and empty=1.
5. Push 6 bytes while the transmitter is busy -> count=4, full=1, overrun=1. Write 0x0040 to 0x0003 -> overrun=0. Only 5 frames are transmitted: the first byte is popped immediately, 4 fill the FIFO, the 6th is dropped.
6. TIMER_PRESCALE=2. Write 0xFFFE to TCOUNT, 1 to TCTRL -> count 0xFFFF after 2 cycles, 0x0000 after 4 with ovf=1 and timer_irq=1. Write 0x0003 to TCTRL in the same cycle as an overflow -> ovf stays 1. Assert rst_n=0 mid-frame -> uart_tx=1 and all registers cleared asynchronously.
